// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_e : transaction phase of the single shared DRAM port
//   arb_owner_e : which requester owns the outstanding transaction
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // Instruction fetches always move a full word.
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch (IF) and load/store (LSU) requests onto a single
// DRAM port with at most one transaction outstanding. LSU has priority, but IF
// is forced through after MAX_DATA_STREAK consecutive LSU wins while IF waits.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   if_req_ip / if_addr_ip       IF request and word address
//   if_gnt_op / if_rvalid_op / if_rdata_op     IF grant, response, data
//   lsu_req_ip / lsu_we_ip / lsu_be_ip / lsu_addr_ip / lsu_wdata_ip   LSU request
//   lsu_gnt_op / lsu_rvalid_op / lsu_rdata_op  LSU grant, response, data
//   mem_req_op / mem_we_op / mem_be_op / mem_addr_op / mem_wdata_op   DRAM request
//   mem_gnt_ip / mem_rvalid_ip / mem_rdata_ip  DRAM accept, response, data
//   busy_op                      transaction outstanding
//   proto_err_op                 sticky: DRAM handshake seen in the wrong phase
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_ip,
    input  logic [31:0] if_addr_ip,
    output logic        if_gnt_op,
    output logic        if_rvalid_op,
    output logic [31:0] if_rdata_op,

    input  logic        lsu_req_ip,
    input  logic        lsu_we_ip,
    input  logic [3:0]  lsu_be_ip,
    input  logic [31:0] lsu_addr_ip,
    input  logic [31:0] lsu_wdata_ip,
    output logic        lsu_gnt_op,
    output logic        lsu_rvalid_op,
    output logic [31:0] lsu_rdata_op,

    output logic        mem_req_op,
    output logic        mem_we_op,
    output logic [3:0]  mem_be_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic        mem_gnt_ip,
    input  logic        mem_rvalid_ip,
    input  logic [31:0] mem_rdata_ip,

    output logic        busy_op,
    output logic        proto_err_op
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  streak_q, streak_d;
    logic        err_q, err_d;

    logic any_req;
    logic if_wins;
    logic in_req;
    logic in_resp;
    logic rsp_fire;

    assign any_req = if_req_ip | lsu_req_ip;
    // IF only beats a simultaneous LSU request once the streak limit is hit.
    assign if_wins = if_req_ip & (~lsu_req_ip | (streak_q == STREAK_MAX));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = REQ;
                    if (if_wins) begin
                        owner_d  = OWN_IF;
                        we_d     = 1'b0;
                        be_d     = BE_WORD;
                        addr_d   = if_addr_ip;
                        wdata_d  = '0;
                        streak_d = '0;
                    end else begin
                        owner_d = OWN_LSU;
                        we_d    = lsu_we_ip;
                        be_d    = lsu_be_ip;
                        addr_d  = lsu_addr_ip;
                        wdata_d = lsu_wdata_ip;
                        // Only LSU wins that make IF wait count towards the streak.
                        if (!if_req_ip) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            REQ: begin
                if (mem_gnt_ip) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_ip) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshakes in the wrong phase are ignored but remembered until reset.
        if ((mem_rvalid_ip && (state_q != RESP)) || (mem_gnt_ip && (state_q != REQ))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign in_req   = (state_q == REQ);
    assign in_resp  = (state_q == RESP);
    assign rsp_fire = in_resp & mem_rvalid_ip;

    // Request fields are only driven while the request is presented.
    assign mem_req_op   = in_req;
    assign mem_we_op    = in_req & we_q;
    assign mem_be_op    = in_req ? be_q : '0;
    assign mem_addr_op  = in_req ? addr_q : '0;
    assign mem_wdata_op = in_req ? wdata_q : '0;

    assign if_gnt_op  = in_req & mem_gnt_ip & (owner_q == OWN_IF);
    assign lsu_gnt_op = in_req & mem_gnt_ip & (owner_q == OWN_LSU);

    assign if_rvalid_op  = rsp_fire & (owner_q == OWN_IF);
    assign lsu_rvalid_op = rsp_fire & (owner_q == OWN_LSU);
    assign if_rdata_op   = if_rvalid_op ? mem_rdata_ip : '0;
    // Store completions carry no data back.
    assign lsu_rdata_op  = (lsu_rvalid_op & ~we_q) ? mem_rdata_ip : '0;

    assign busy_op      = (state_q != IDLE);
    assign proto_err_op = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester/memory agents drive stimulus,
// a transaction-level model checks every output on every falling edge, and a
// few hand-computed literals pin the scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, lsu_req, lsu_we;
    logic [31:0] if_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_be;
    logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid;
    logic [31:0] if_rdata, lsu_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, proto_err;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clock(clock), .reset(reset),
        .if_req_ip(if_req), .if_addr_ip(if_addr),
        .if_gnt_op(if_gnt), .if_rvalid_op(if_rvalid), .if_rdata_op(if_rdata),
        .lsu_req_ip(lsu_req), .lsu_we_ip(lsu_we), .lsu_be_ip(lsu_be),
        .lsu_addr_ip(lsu_addr), .lsu_wdata_ip(lsu_wdata),
        .lsu_gnt_op(lsu_gnt), .lsu_rvalid_op(lsu_rvalid), .lsu_rdata_op(lsu_rdata),
        .mem_req_op(mem_req), .mem_we_op(mem_we), .mem_be_op(mem_be),
        .mem_addr_op(mem_addr), .mem_wdata_op(mem_wdata),
        .mem_gnt_ip(mem_gnt), .mem_rvalid_ip(mem_rvalid), .mem_rdata_ip(mem_rdata),
        .busy_op(busy), .proto_err_op(proto_err)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        lsu;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic m_have, m_acc, m_err;
    int   m_run;   // consecutive LSU wins that left IF waiting
    txn_t m_txn;

    // statistics collected by the compare process
    int          cyc = 0;
    int          n_if_gnt, n_if_rv, n_lsu_gnt, n_lsu_rv, n_mem_req;
    int          req_start_cyc, gnt_cyc, rv_cyc;
    logic [31:0] last_if_rdata, last_lsu_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        prev_mem_req;
    bit          grant_log[$];
    logic        seen_if_gnt, seen_lsu_gnt;

    always @(negedge clock) begin
        logic exp_req, exp_rsp;
        cyc++;
        if (!reset) begin
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_err", proto_err, 1'b0);
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_handshakes", if_gnt | if_rvalid | lsu_gnt | lsu_rvalid, 1'b0);
            chk32("rst_data", mem_addr | mem_wdata | if_rdata | lsu_rdata, 32'h0);
            m_have = 1'b0;
            m_acc  = 1'b0;
            m_err  = 1'b0;
            m_run  = 0;
            prev_mem_req = 1'b0;
        end else begin
            exp_req = m_have && !m_acc;
            exp_rsp = m_have && m_acc && mem_rvalid;
            chk1("mem_req", mem_req, exp_req);
            chk1("mem_we", mem_we, exp_req ? m_txn.we : 1'b0);
            chk32("mem_be", {28'h0, mem_be}, exp_req ? {28'h0, m_txn.be} : 32'h0);
            chk32("mem_addr", mem_addr, exp_req ? m_txn.addr : 32'h0);
            chk32("mem_wdata", mem_wdata, exp_req ? m_txn.wdata : 32'h0);
            chk1("if_gnt", if_gnt, exp_req && mem_gnt && !m_txn.lsu);
            chk1("lsu_gnt", lsu_gnt, exp_req && mem_gnt && m_txn.lsu);
            chk1("if_rvalid", if_rvalid, exp_rsp && !m_txn.lsu);
            chk32("if_rdata", if_rdata, (exp_rsp && !m_txn.lsu) ? mem_rdata : 32'h0);
            chk1("lsu_rvalid", lsu_rvalid, exp_rsp && m_txn.lsu);
            chk32("lsu_rdata", lsu_rdata,
                  (exp_rsp && m_txn.lsu && !m_txn.we) ? mem_rdata : 32'h0);
            chk1("busy", busy, m_have);
            chk1("proto_err", proto_err, m_err);

            // statistics from the DUT (used only for scenario literals)
            if (mem_req) n_mem_req++;
            if (mem_req && !prev_mem_req) req_start_cyc = cyc;
            prev_mem_req = mem_req;
            if (if_gnt) begin
                n_if_gnt++; gnt_cyc = cyc; seen_if_gnt = 1'b1; grant_log.push_back(1'b0);
            end
            if (lsu_gnt) begin
                n_lsu_gnt++; gnt_cyc = cyc; seen_lsu_gnt = 1'b1; grant_log.push_back(1'b1);
                cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be;
            end
            if (if_rvalid) begin n_if_rv++; rv_cyc = cyc; last_if_rdata = if_rdata; end
            if (lsu_rvalid) begin n_lsu_rv++; rv_cyc = cyc; last_lsu_rdata = lsu_rdata; end

            // advance the model across the coming rising edge
            if ((mem_rvalid && !(m_have && m_acc)) || (mem_gnt && !exp_req)) m_err = 1'b1;
            if (!m_have) begin
                if (if_req || lsu_req) begin
                    if (if_req && (!lsu_req || m_run >= int'(MAX))) begin
                        m_txn = '{lsu: 1'b0, we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'h0};
                        m_run = 0;
                    end else begin
                        m_txn = '{lsu: 1'b1, we: lsu_we, be: lsu_be, addr: lsu_addr,
                                  wdata: lsu_wdata};
                        m_run = if_req ? ((m_run < int'(MAX)) ? m_run + 1 : m_run) : 0;
                    end
                    m_have = 1'b1;
                    m_acc  = 1'b0;
                end
            end else if (!m_acc) begin
                if (mem_gnt) m_acc = 1'b1;
            end else if (mem_rvalid) begin
                m_have = 1'b0;
            end
        end
    end

    // ---------------- agents ----------------
    int          if_todo, lsu_todo;
    int          gnt_delay, rv_delay, gnt_wait, rv_wait;
    logic        rv_pending, force_rvalid, force_gnt, lsu_drop;
    logic [31:0] rd_value;

    task automatic clear_stats();
        n_if_gnt = 0; n_if_rv = 0; n_lsu_gnt = 0; n_lsu_rv = 0; n_mem_req = 0;
        req_start_cyc = 0; gnt_cyc = 0; rv_cyc = 0;
        last_if_rdata = 32'hx; last_lsu_rdata = 32'hx;
        grant_log.delete();
    endtask

    task automatic set_mem(input int g, input int r);
        gnt_delay = g; gnt_wait = g; rv_delay = r;
    endtask

    // Update agent-driven inputs for the current cycle, then move to next edge + 1.
    task automatic step();
        if (seen_if_gnt) begin
            seen_if_gnt = 1'b0;
            if (if_todo > 0) if_todo--;
            if_addr += 32'd4;
        end
        if (seen_lsu_gnt) begin
            seen_lsu_gnt = 1'b0;
            if (lsu_todo > 0) lsu_todo--;
            lsu_addr  += 32'd4;
            lsu_we     = ~lsu_we;
            lsu_wdata += 32'd1;
            lsu_be     = {lsu_be[2:0], lsu_be[3]};
        end
        // LSU walks away after its request is latched; the latched copy must survive.
        if (lsu_drop && mem_req) begin
            lsu_drop = 1'b0; lsu_todo = 0;
            lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h0; lsu_be = 4'h0;
        end
        if_req  = (if_todo > 0);
        lsu_req = (lsu_todo > 0);

        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        if (force_rvalid) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h55; force_rvalid = 1'b0;
        end else if (force_gnt) begin
            mem_gnt = 1'b1; force_gnt = 1'b0;
        end else if (rv_pending) begin
            if (rv_wait == 0) begin
                mem_rvalid = 1'b1; mem_rdata = rd_value; rv_pending = 1'b0;
            end else rv_wait--;
        end else if (mem_req) begin
            if (gnt_wait == 0) begin
                mem_gnt = 1'b1; rv_pending = 1'b1; rv_wait = rv_delay; gnt_wait = gnt_delay;
                rd_value = mem_we ? 32'hFFFF_FFFF : mem_addr + 32'd3;
            end else gnt_wait--;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(if_todo == 0 && lsu_todo == 0 && !rv_pending && !busy) && n < budget);
        chk1({name, "_in_budget"}, n < budget, 1'b1);
    endtask

    task automatic agents_idle();
        if_todo = 0; lsu_todo = 0; rv_pending = 1'b0; force_rvalid = 1'b0; force_gnt = 1'b0;
        lsu_drop = 1'b0; seen_if_gnt = 1'b0; seen_lsu_gnt = 1'b0;
        if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        agents_idle();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    bit exp_seq [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        if_addr = 32'h0; lsu_we = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        agents_idle();
        set_mem(0, 0);
        clear_stats();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Reset state
        chk1("init_busy", busy, 1'b0);
        chk1("init_err", proto_err, 1'b0);
        chk1("init_mem_req", mem_req, 1'b0);

        // Single IF read of 0x10; gnt with the request, rvalid two cycles after gnt
        clear_stats(); set_mem(0, 1);
        if_addr = 32'h10; if_todo = 1;
        run_until_idle("t1", 30);
        chk32("t1_if_gnt_count", n_if_gnt, 1);
        chk32("t1_if_rv_count", n_if_rv, 1);
        chk32("t1_if_rdata", last_if_rdata, 32'h0000_0013);
        chk32("t1_gnt_latency", gnt_cyc - req_start_cyc, 0);
        chk32("t1_rv_latency", rv_cyc - gnt_cyc, 2);
        chk1("t1_busy_after", busy, 1'b0);

        // IF waits behind a continuous LSU stream: 4 LSU, 1 IF, LSU resumes
        clear_stats(); set_mem(0, 0);
        if_addr = 32'h40; if_todo = 1;
        lsu_addr = 32'h100; lsu_we = 1'b0; lsu_be = 4'hF; lsu_wdata = 32'h1111_0000;
        lsu_todo = 6;
        run_until_idle("t2", 80);
        chk32("t2_grant_count", grant_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk1($sformatf("t2_grant%0d_is_lsu", i),
                 (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_seq[i]);
        end
        chk32("t2_if_rdata", last_if_rdata, 32'h0000_0043);

        // LSU store held off 3 cycles; requester drops its request after latching
        clear_stats(); set_mem(3, 0);
        lsu_addr = 32'h200; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_wdata = 32'hDEAD_BEEF;
        lsu_todo = 1; lsu_drop = 1'b1;
        run_until_idle("t3", 30);
        chk32("t3_req_cycles", n_mem_req, 4);
        chk32("t3_lsu_gnt_count", n_lsu_gnt, 1);
        chk32("t3_addr_at_gnt", cap_addr, 32'h200);
        chk32("t3_wdata_at_gnt", cap_wdata, 32'hDEAD_BEEF);
        chk32("t3_be_at_gnt", {28'h0, cap_be}, 32'h3);
        chk32("t3_lsu_rv_count", n_lsu_rv, 1);
        chk32("t3_lsu_rdata", last_lsu_rdata, 32'h0);

        // Stray rvalid in IDLE: ignored, sticky error
        clear_stats(); set_mem(0, 0);
        force_rvalid = 1'b1;
        step(); step();
        chk1("t4_err_set", proto_err, 1'b1);
        chk32("t4_no_response", n_if_rv + n_lsu_rv, 0);
        if_addr = 32'h20; if_todo = 1;
        run_until_idle("t4", 30);
        chk32("t4_if_rv_count", n_if_rv, 1);
        chk1("t4_err_sticky", proto_err, 1'b1);
        do_reset();
        chk1("t4_err_cleared", proto_err, 1'b0);

        // Reset while in RESP drops the transaction
        clear_stats(); set_mem(0, 4);
        if_addr = 32'h80; if_todo = 1;
        for (int i = 0; i < 10 && !rv_pending; i++) step();
        chk1("t5_in_resp", busy & ~mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk32("t5_outputs_zero",
              {25'h0, busy, proto_err, mem_req, if_gnt, if_rvalid, lsu_gnt, lsu_rvalid}, 32'h0);
        agents_idle();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        force_rvalid = 1'b1;
        step(); step();
        chk1("t5_late_rvalid_err", proto_err, 1'b1);
        chk32("t5_no_response", n_if_rv, 0);
        set_mem(0, 0);
        if_addr = 32'h90; if_todo = 1;
        run_until_idle("t5", 30);
        chk32("t5_if_rv_count", n_if_rv, 1);
        chk32("t5_if_rdata", last_if_rdata, 32'h0000_0093);

        // Stray gnt in IDLE also raises the error
        do_reset();
        force_gnt = 1'b1;
        step(); step();
        chk1("t6_gnt_err", proto_err, 1'b1);
        chk1("t6_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_DATA_STREAK, 4, consecutive LSU grants allowed while IF waits (range 1..15).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port: clock  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: if_req_ip in 1, if_addr_ip in 32: instruction-fetch request and word address.
REQ-006 Ports: if_gnt_op out 1, if_rvalid_op out 1, if_rdata_op out 32: IF grant pulse, response pulse, fetched word.
REQ-007 Ports: lsu_req_ip in 1, lsu_we_ip in 1, lsu_be_ip in 4, lsu_addr_ip in 32, lsu_wdata_ip in 32: LSU request, write flag, byte enables, address, store data.
REQ-008 Ports: lsu_gnt_op out 1, lsu_rvalid_op out 1, lsu_rdata_op out 32: LSU grant pulse, response pulse, load data.
REQ-009 Ports: mem_req_op out 1, mem_we_op out 1, mem_be_op out 4, mem_addr_op out 32, mem_wdata_op out 32: single shared DRAM port request.
REQ-010 Ports: mem_gnt_ip in 1, mem_rvalid_ip in 1, mem_rdata_ip in 32: DRAM accept, response, read data.
REQ-011 Ports: busy_op out 1 (transaction outstanding); proto_err_op out 1 (sticky protocol error).

Function
REQ-012 States: IDLE, REQ, RESP; at most one transaction outstanding.
REQ-013 IDLE with any request: arbitrate, latch owner and winner's fields into request registers, go to REQ next edge.
REQ-014 Priority: LSU wins, except when if_req_ip=1 and streak counter = MAX_DATA_STREAK, then IF wins.
REQ-015 Streak counter: +1 on each LSU win while if_req_ip=1; cleared on IF win or any arbitration with if_req_ip=0; saturates at MAX_DATA_STREAK.
REQ-016 REQ: mem_req_op=1 with latched fields held stable until mem_gnt_ip=1; no retraction or re-arbitration.
REQ-017 REQ with mem_gnt_ip=1: pulse owner's gnt output for exactly that cycle; go to RESP.
REQ-018 RESP with mem_rvalid_ip=1: owner's rvalid_op=1 for one cycle and rdata_op=mem_rdata_ip in that cycle; go to IDLE.
REQ-019 Writes: also complete via mem_rvalid_ip; lsu_rvalid_op pulses, lsu_rdata_op=0.
REQ-020 Non-owner gnt/rvalid outputs are 0; all rdata outputs are 0 when their rvalid is 0.
REQ-021 IF requests: mem_we_op=0, mem_be_op=4'hF, mem_wdata_op=0.
REQ-022 Requesters hold req/fields until their gnt; deassertion in REQ does not cancel the latched transaction.
REQ-023 Minimum latency: request at IDLE cycle n -> mem_req_op at n+1 -> gnt at n+1 earliest -> rvalid at n+2 earliest; back-to-back requests spaced ≥3 cycles.
REQ-024 mem_rvalid_ip=1 in IDLE or REQ, or mem_gnt_ip=1 outside REQ: ignored, proto_err_op set to 1 until reset.
REQ-025 busy_op=1 in REQ and RESP, 0 in IDLE.
REQ-026 Simultaneous IF and LSU requests with streak < MAX_DATA_STREAK: LSU wins, IF stays pending.

Reset
REQ-027 reset=0 forces IDLE asynchronously, including mid-REQ or mid-RESP; outstanding transaction is dropped without response.
REQ-028 Reset values: every output 0, request registers 0, streak counter 0, proto_err_op 0.
REQ-029 First request is sampled at the first rising edge with reset=1.

Structure
REQ-030 arb_state_e (IDLE/REQ/RESP) and arb_owner_e (OWN_IF/OWN_LSU) live in CORE_PKG.
REQ-031 Block is flat; no sub-module. Next-state, arbitration and response routing are combinational; state, owner, request fields, streak and error are registered.

Verification
REQ-032 Single IF read of 0x10, gnt same cycle as mem_req, rvalid 2 cycles later with 0x00000013 -> if_gnt_op one pulse, if_rvalid_op one pulse, if_rdata_op=0x00000013, busy_op 0 afterwards.
REQ-033 IF and LSU requesting together, continuous LSU -> 4 LSU grants, then 1 IF grant, then LSU resumes (MAX_DATA_STREAK=4).
REQ-034 LSU store addr 0x200, be 4'b0011, data 0xDEADBEEF, gnt held off 3 cycles -> mem_* fields stable for all 4 REQ cycles; lsu_rvalid_op pulses with lsu_rdata_op=0.
REQ-035 mem_rvalid_ip pulsed in IDLE -> no rvalid output, proto_err_op=1 and stays 1 until reset.
REQ-036 reset asserted while in RESP -> all outputs 0 immediately; later mem_rvalid_ip ignored apart from setting proto_err_op; next request served normally.
